// File: rtl/serial_paralelo.sv
// serial_paralelo: receive-side deserializer.
// Aligns byte boundaries to the comma symbol and emits received bytes.
module serial_paralelo #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned COMMA_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] CC = 4'(COMMA_COUNT);

  state_t     state;
  state_t     state_nx;
  logic [6:0] shift_reg;
  logic [7:0] window;
  logic       is_comma;
  logic       boundary;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_nx;
  logic [3:0] bc_cnt;
  logic [3:0] bc_cnt_nx;
  logic [7:0] data_nx;
  logic       valid_nx;
  logic       strobe_nx;

  // Only the 7 older bits are stored; the newest is data_in itself.
  assign window   = {shift_reg, data_in};
  assign is_comma = (window == COMMA);
  assign boundary = (bit_cnt == 3'd7);

  // Alignment FSM and output next-values.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt + 3'd1;
    bc_cnt_nx  = bc_cnt;
    data_nx    = data_out;
    valid_nx   = 1'b0;
    strobe_nx  = 1'b0;
    unique case (state)
      SEARCH: begin
        bit_cnt_nx = bit_cnt;
        if (is_comma) begin
          bit_cnt_nx = 3'd0;
          bc_cnt_nx  = 4'd1;
          state_nx   = (CC == 4'd1) ? ACTIVE : LOCK;
        end
      end
      LOCK: begin
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_nx = bc_cnt + 4'd1;
            if (bc_cnt_nx == CC)
              state_nx = ACTIVE;
          end else begin
            bc_cnt_nx = 4'd0;
            state_nx  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          strobe_nx = 1'b1;
          if (!is_comma) begin
            valid_nx = 1'b1;
            data_nx  = window;
          end
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // State, counters, shift history and registered outputs.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nx;
      shift_reg   <= window[6:0];
      bit_cnt     <= bit_cnt_nx;
      bc_cnt      <= bc_cnt_nx;
      data_out    <= data_nx;
      valid_out   <= valid_nx;
      byte_strobe <= strobe_nx;
      active      <= (state_nx == ACTIVE);
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: bench for the comma-aligned deserializer.
// Expected outputs come from a stream-level model of the lock rules.
module tb_serial_paralelo;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int CC   = 4;
  localparam int MAXB = 512;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_checks = 0;
  int n_pass   = 0;

  bit          bitq[$];
  logic [10:0] obs[MAXB];
  logic [10:0] expv[MAXB];

  serial_paralelo #(.COMMA(COMMA), .COMMA_COUNT(CC)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  always #5 clk_32f = ~clk_32f;

  // Byte whose last bit is sampled at edge e (1-based); zeros before reset.
  function automatic logic [7:0] win(int e);
    logic [7:0] w;
    int idx;
    w = '0;
    for (int t = 0; t < 8; t++) begin
      idx = e - 8 + t;
      w = {w[6:0], (idx >= 0) && (bitq[idx] == 1'b1)};
    end
    return w;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
  endtask

  // Find the lock edge by scanning the stream, then derive every edge.
  task automatic model();
    int n, i, j, k, lk;
    bit ok, act, str, val;
    logic [7:0] d;
    n  = bitq.size();
    lk = 0;
    i  = 1;
    while (i <= n && lk == 0) begin
      if (win(i) == COMMA) begin
        k  = 1;
        ok = 1;
        while (k < CC && ok) begin
          j = i + 8 * k;
          if (j > n) begin
            ok = 0;
            i  = n + 1;
          end else if (win(j) == COMMA) begin
            k++;
          end else begin
            ok = 0;
            i  = j + 1;
          end
        end
        if (ok) lk = i + 8 * (CC - 1);
      end else begin
        i++;
      end
    end
    d = '0;
    for (int e = 1; e <= n; e++) begin
      act = (lk != 0) && (e >= lk);
      str = (lk != 0) && (e > lk) && ((e - lk) % 8 == 0);
      val = str && (win(e) != COMMA);
      if (val) d = win(e);
      expv[e-1] = {d, val, str, act};
    end
  endtask

  task automatic drive();
    for (int e = 0; e < bitq.size(); e++) begin
      @(negedge clk_32f);
      data_in = bitq[e];
      @(posedge clk_32f);
      #1;
      obs[e] = {data_out, valid_out, byte_strobe, active};
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'($urandom);
    repeat (3) @(negedge clk_32f);
    @(posedge clk_32f);
    #2;
    reset = 1'b0;
    bitq.delete();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_32f);
      data_in = 1'($urandom);
      @(posedge clk_32f);
      #1;
      n_checks++;
      if ({data_out, valid_out, byte_strobe, active} !== 11'h0)
        $display("FAIL reset cyc %0d: got %h want 000", c,
                 {data_out, valid_out, byte_strobe, active});
      else n_pass++;
    end
    #1;
    reset = 1'b0;
    bitq.delete();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) push_byte(COMMA);
    push_byte(8'hFF);
    model();
    drive();
    for (int e = 0; e < bitq.size(); e++) begin
      n_checks++;
      if (obs[e] !== expv[e])
        $display("FAIL basic edge %0d: got %h want %h", e + 1, obs[e], expv[e]);
      else n_pass++;
    end
    n_checks++;
    if (obs[30][0] !== 1'b0 || obs[31][0] !== 1'b1)
      $display("FAIL basic_active_rise: got %b%b want 01", obs[30][0], obs[31][0]);
    else n_pass++;
    n_checks++;
    if (obs[39] !== {8'hFF, 3'b111})
      $display("FAIL basic_ff: got %h want %h", obs[39], {8'hFF, 3'b111});
    else n_pass++;
  endtask

  task automatic test_align();
    apply_reset();
    bitq.push_back(1'b1);
    bitq.push_back(1'b0);
    bitq.push_back(1'b1);
    for (int i = 0; i < 4; i++) push_byte(COMMA);
    push_byte(8'hEE);
    model();
    drive();
    for (int e = 0; e < bitq.size(); e++) begin
      n_checks++;
      if (obs[e] !== expv[e])
        $display("FAIL align edge %0d: got %h want %h", e + 1, obs[e], expv[e]);
      else n_pass++;
    end
    n_checks++;
    if (obs[42] !== {8'hEE, 3'b111})
      $display("FAIL align_ee: got %h want %h", obs[42], {8'hEE, 3'b111});
    else n_pass++;
  endtask

  task automatic test_relock();
    int bad;
    apply_reset();
    push_byte(COMMA);
    push_byte(COMMA);
    push_byte(8'hAA);
    for (int i = 0; i < 4; i++) push_byte(COMMA);
    push_byte(8'h11);
    model();
    drive();
    for (int e = 0; e < bitq.size(); e++) begin
      n_checks++;
      if (obs[e] !== expv[e])
        $display("FAIL relock edge %0d: got %h want %h", e + 1, obs[e], expv[e]);
      else n_pass++;
    end
    bad = 0;
    for (int e = 0; e < 24; e++) bad += int'(obs[e][0]);
    n_checks++;
    if (bad !== 0) $display("FAIL relock_early_active: got %0d want 0", bad);
    else n_pass++;
    n_checks++;
    if (obs[55][0] !== 1'b1 || obs[63] !== {8'h11, 3'b111})
      $display("FAIL relock_11: got %b/%h want 1/%h", obs[55][0], obs[63],
               {8'h11, 3'b111});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ns;
    apply_reset();
    for (int i = 0; i < 4; i++) push_byte(COMMA);
    push_byte(8'hFF);
    push_byte(8'hEE);
    push_byte(8'hDD);
    push_byte(COMMA);
    push_byte(8'hCC);
    push_byte(8'hBB);
    model();
    drive();
    for (int e = 0; e < bitq.size(); e++) begin
      n_checks++;
      if (obs[e] !== expv[e])
        $display("FAIL b2b edge %0d: got %h want %h", e + 1, obs[e], expv[e]);
      else n_pass++;
    end
    ns = 0;
    for (int e = 0; e < bitq.size(); e++) ns += int'(obs[e][1]);
    n_checks++;
    if (ns !== 6) $display("FAIL b2b_strobes: got %0d want 6", ns);
    else n_pass++;
    n_checks++;
    if (obs[63] !== {8'hDD, 3'b011})
      $display("FAIL b2b_comma_hold: got %h want %h", obs[63], {8'hDD, 3'b011});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) push_byte(COMMA);
    push_byte(8'h5A);
    push_byte(8'h3C);
    drive();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({data_out, valid_out, byte_strobe, active} !== 11'h0)
      $display("FAIL async_reset: got %h want 000",
               {data_out, valid_out, byte_strobe, active});
    else n_pass++;
    repeat (2) @(negedge clk_32f);
    @(posedge clk_32f);
    #2;
    reset = 1'b0;
    bitq.delete();
    for (int i = 0; i < 4; i++) push_byte(COMMA);
    push_byte(8'h22);
    model();
    drive();
    for (int e = 0; e < bitq.size(); e++) begin
      n_checks++;
      if (obs[e] !== expv[e])
        $display("FAIL post_reset edge %0d: got %h want %h", e + 1, obs[e], expv[e]);
      else n_pass++;
    end
    n_checks++;
    if (obs[30][0] !== 1'b0 || obs[31][0] !== 1'b1)
      $display("FAIL post_reset_lock: got %b%b want 01", obs[30][0], obs[31][0]);
    else n_pass++;
  endtask

  task automatic test_random();
    int nj;
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      nj = $urandom_range(0, 15);
      for (int i = 0; i < nj; i++) bitq.push_back(1'($urandom));
      for (int i = 0; i < 4; i++) push_byte(COMMA);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) push_byte(COMMA);
        else push_byte(8'($urandom));
      end
      model();
      drive();
      for (int e = 0; e < bitq.size(); e++) begin
        n_checks++;
        if (obs[e] !== expv[e])
          $display("FAIL random r%0d edge %0d: got %h want %h", r, e + 1,
                   obs[e], expv[e]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_align();
    test_relock();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
